// File: rtl/demux1to4_router_pkg.sv
// rtl/demux1to4_router_pkg.sv - shared lane count, select width, lane state and counter width defaults.
package demux1to4_router_pkg;

  localparam int NUM_LANES     = 4;
  localparam int SEL_W         = 2;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux1to4_router_demux_lane.sv
// rtl/demux1to4_router_demux_lane.sv - one-entry lane holding register with drain/accept FSM.
// Per-lane saturating handshake counter present only when ROUTER_STATS_EN is defined.
module demux_lane
  import demux1to4_router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             accept,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
`ifdef ROUTER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  lane_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LANE_EMPTY;
    else     state_q <= state_d;
  end

  // accept never coincides with flush because in_ready is forced low during flush
  always_comb begin
    state_d = state_q;
    case (state_q)
      LANE_EMPTY: if (accept) state_d = LANE_FULL;
      LANE_FULL:  if (!accept && out_ready) state_d = LANE_EMPTY;
      default:    state_d = LANE_EMPTY;
    endcase
    if (flush) state_d = LANE_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_data <= '0;
    else if (accept) out_data <= in_data;
  end

  assign out_valid = (state_q == LANE_FULL);

`ifdef ROUTER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         cnt <= '0;
    else if (out_valid && out_ready && (cnt != '1)) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/demux1to4_router.sv
// rtl/demux1to4_router.sv - registered 1-to-4 valid/ready demultiplexer; select decode and in_ready only.
// Optional per-lane transfer counters cnt0..cnt3 under ROUTER_STATS_EN.
module demux1to4_router
  import demux1to4_router_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data0,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2,
  output logic [WIDTH-1:0]     out_data3,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready
`ifdef ROUTER_STATS_EN
  ,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1,
  output logic [CNT_W-1:0]     cnt2,
  output logic [CNT_W-1:0]     cnt3
`endif
);

  logic                 accept;
  logic [NUM_LANES-1:0] lane_accept;
  logic [WIDTH-1:0]     lane_data [NUM_LANES];
`ifdef ROUTER_STATS_EN
  logic [CNT_W-1:0]     lane_cnt  [NUM_LANES];
`endif

  // ready depends only on registered lane state of the presented select, never on in_valid
  assign in_ready = ~flush & (~out_valid[in_sel] | out_ready[in_sel]);
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_accept[g] = accept & (in_sel == SEL_W'(g));

    demux_lane #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .accept    (lane_accept[g]),
      .in_data   (in_data),
      .out_ready (out_ready[g]),
      .out_data  (lane_data[g]),
      .out_valid (out_valid[g])
`ifdef ROUTER_STATS_EN
      ,
      .cnt       (lane_cnt[g])
`endif
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];

`ifdef ROUTER_STATS_EN
  assign cnt0 = lane_cnt[0];
  assign cnt1 = lane_cnt[1];
  assign cnt2 = lane_cnt[2];
  assign cnt3 = lane_cnt[3];
`endif

endmodule

// File: tb/tb_demux1to4_router.sv
// tb/tb_demux1to4_router.sv - self-checking bench for demux1to4_router with a per-lane mailbox model.
// Counter checks are compiled in only when ROUTER_STATS_EN is defined.
module tb_demux1to4_router;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
  logic [3:0]    out_valid, out_ready;
`ifdef ROUTER_STATS_EN
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int tests = 0;
  int fails = 0;

  // model: each lane is a one-slot mailbox holding a word until its consumer takes it
  bit          m_full [4];
  logic [W-1:0] m_data [4];
  int          m_cnt  [4];

  demux1to4_router #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ROUTER_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_data(int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

`ifdef ROUTER_STATS_EN
  function automatic int dut_cnt(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction
`endif

  function automatic bit m_ready();
    return !flush && (!m_full[in_sel] || out_ready[in_sel]);
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  task automatic m_clear(bit with_cnt);
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      if (with_cnt) begin
        m_data[i] = '0;
        m_cnt[i]  = 0;
      end
    end
  endtask

  // advance the model over one clock edge using the inputs currently presented
  task automatic cyc();
    bit acc;
    acc = in_valid && m_ready();
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && out_ready[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      if (flush) m_full[i] = 1'b0;
      else if (acc && in_sel == i) begin
        m_full[i] = 1'b1;
        m_data[i] = in_data;
      end else if (out_ready[i]) m_full[i] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int sel, logic [W-1:0] d);
    in_sel = 2'(sel); in_data = d; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    m_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid got %b exp 0000", out_valid); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut_data(i) !== '0) begin fails++; $display("FAIL reset_data%0d got %h exp 0", i, dut_data(i)); end
    end
`ifdef ROUTER_STATS_EN
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut_cnt(i) !== 0) begin fails++; $display("FAIL reset_cnt%0d got %0d exp 0", i, dut_cnt(i)); end
    end
`endif
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_route();
    in_sel = 2; in_data = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 4'b0000;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL route_ready got %b exp 1", in_ready); end
    cyc();
    tests++; if (out_valid !== 4'b0100) begin fails++; $display("FAIL route_valid got %b exp 0100", out_valid); end
    tests++; if (out_data2 !== 32'hDEADBEEF) begin fails++; $display("FAIL route_data2 got %h exp deadbeef", out_data2); end
    in_data = 32'h12345678;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL route_blocked_lane2 got %b exp 0", in_ready); end
    in_sel = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL route_free_lane1 got %b exp 1", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      in_sel = 0; in_data = W'(k); in_valid = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready word %0d got %b exp 1", k, in_ready); end
      cyc();
      tests++; if (out_valid[0] !== 1'b1 || out_data0 !== W'(k)) begin
        fails++; $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", k, out_valid[0], out_data0, k);
      end
    end
    in_valid = 1'b0;
    cyc();
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL stream_drain got %b exp 0", out_valid[0]); end
  endtask

  task automatic test_stall();
    out_ready = 4'b0011;
    send(3, 32'h55);
    for (int k = 0; k < 5; k++) begin
      send(k % 2, 32'h100 + k);
      tests++; if (out_data3 !== 32'h55 || out_valid[3] !== 1'b1) begin
        fails++; $display("FAIL stall_lane3 cyc %0d got v=%b d=%h exp v=1 d=55", k, out_valid[3], out_data3);
      end
      tests++; if (out_valid[k % 2] !== 1'b1 || dut_data(k % 2) !== 32'h100 + k) begin
        fails++; $display("FAIL stall_other lane %0d got v=%b d=%h exp v=1 d=%h", k % 2, out_valid[k % 2], dut_data(k % 2), 32'h100 + k);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 4'b1111;
    cyc();
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) send(i, 32'hA0 + i);
    tests++; if (out_valid !== 4'b1111) begin fails++; $display("FAIL flush_fill got %b exp 1111", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_sel = 0; in_data = 32'hBAD0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL flush_valid got %b exp 0000", out_valid); end
    tests++; if (out_data0 !== 32'hA0) begin fails++; $display("FAIL flush_no_accept got %h exp a0", out_data0); end
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    send(0, 32'h11);
    send(2, 32'h22);
    tests++; if (out_valid !== 4'b0101) begin fails++; $display("FAIL arst_fill got %b exp 0101", out_valid); end
    #2;
    rst = 1'b1; in_sel = 2;
    m_clear(1'b1);
    #1;
    tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL arst_valid got %b exp 0000", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got %b exp 1", in_ready); end
`ifdef ROUTER_STATS_EN
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut_cnt(i) !== 0) begin fails++; $display("FAIL arst_cnt%0d got %0d exp 0", i, dut_cnt(i)); end
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef ROUTER_STATS_EN
  task automatic test_saturation();
    out_ready = 4'b0010;
    for (int k = 0; k < 20; k++) send(1, W'(k));
    cyc();
    tests++; if (cnt1 !== 4'd15) begin fails++; $display("FAIL sat_cnt1 got %0d exp 15", cnt1); end
    send(1, 32'h77);
    cyc();
    tests++; if (cnt1 !== 4'd15) begin fails++; $display("FAIL sat_hold got %0d exp 15", cnt1); end
    tests++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL sat_cnt0 got %0d exp 0", cnt0); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(15) == 0);
      in_valid  = $urandom_range(1);
      in_sel    = 2'($urandom_range(3));
      in_data   = $urandom;
      out_ready = 4'($urandom_range(15));
      #1;
      tests++; if (in_ready !== m_ready()) begin
        fails++; $display("FAIL rand_ready cyc %0d got %b exp %b", n, in_ready, m_ready());
      end
      cyc();
      tests++; if (out_valid !== m_valid()) begin
        fails++; $display("FAIL rand_valid cyc %0d got %b exp %b", n, out_valid, m_valid());
      end
      for (int i = 0; i < 4; i++) begin
        if (m_full[i]) begin
          tests++; if (dut_data(i) !== m_data[i]) begin
            fails++; $display("FAIL rand_data lane %0d cyc %0d got %h exp %h", i, n, dut_data(i), m_data[i]);
          end
        end
`ifdef ROUTER_STATS_EN
        tests++; if (dut_cnt(i) !== m_cnt[i]) begin
          fails++; $display("FAIL rand_cnt lane %0d cyc %0d got %0d exp %0d", i, n, dut_cnt(i), m_cnt[i]);
        end
`endif
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_route();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
`ifdef ROUTER_STATS_EN
    test_saturation();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux1to4_router.md
Name: demux1to4_router

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes on every port.
- One input stream of WIDTH-bit words carries a 2-bit destination select; each accepted word is steered into a one-entry holding register for that lane.
- Used where one producer (e.g. write-back result) feeds one of four consumers, the inverse of the 4-to-1 selectors in the datapath.

Parameters:
- WIDTH, 32, data word width.
- CNT_W, 16, width of per-lane transfer counters (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all lane holding registers.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination lane 0..3.
- in_valid  input  1  input word valid.
- in_ready  output  1  router accepts word this cycle.
- out_data0..out_data3  output  WIDTH each  lane data.
- out_valid  output  4  per-lane valid, bit i = lane i.
- out_ready  input  4  per-lane consumer ready.
- cnt0..cnt3  output  CNT_W each  per-lane transfer count (ROUTER_STATS_EN only).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high: it clears all lanes immediately, independent of clk.
- Reset values: out_valid=0, out_data0..3=0, counters=0.
- in_ready is combinational from registered state only; it does not depend on in_valid:
  - in_ready = ~flush & (~out_valid[in_sel] | out_ready[in_sel]).
- Lane state machine (per lane i), two states:
  - EMPTY -> FULL: accept (in_valid & in_ready & in_sel==i). out_data_i is loaded.
  - FULL -> EMPTY: drain (out_ready[i]) with no accept to lane i.
  - FULL -> FULL: drain and accept on the same edge. New data replaces old; no bubble.
  - FULL holding with out_ready[i]=0: out_data_i and out_valid[i] stay stable.
- Accept rules:
  - At most one accept per cycle. The other three lanes are unaffected by an accept to lane i.
  - Latency: a word accepted at edge N appears on out_data_i with out_valid[i]=1 after edge N.
- Back-pressure: a blocked lane blocks only words addressed to it. in_ready reflects the currently presented in_sel.
- Data outside handshakes:
  - out_data_i holds its last value when EMPTY; consumers must ignore it.
  - in_data is don't-care when in_valid=0.
- flush=1: in_ready=0 that cycle, and all out_valid bits clear at the next edge. Counters are not cleared.
- Asynchronous reset mid-transfer: any word held or presented is dropped, out_valid goes to 0 at once, and in_ready follows the formula with the cleared state.
- No word is ever duplicated or delivered to a lane other than in_sel at acceptance.

Optional Feature:
- Macro ROUTER_STATS_EN.
- Defined:
  - cnt_i increments by 1 on each completed output handshake (out_valid[i] & out_ready[i]).
  - Counters saturate at all-ones and do not wrap.
  - Counters are cleared only by rst.
- Undefined: cnt0..cnt3 ports and counter logic are absent, and the port list ends at out_ready.

Decomposition:
- Shared package:
  - NUM_LANES=4 and SEL_W=2.
  - lane_state_t enum {LANE_EMPTY, LANE_FULL}.
  - CNT_W default value.
- Sub-module demux_lane: one holding register, state, drain/accept logic and the optional counter. It is instantiated four times. The top level holds only select decode and in_ready.

Test Plan:
- Reset then route:
  - Stimulus: rst pulse, then in_sel=2, in_data=0xDEADBEEF, in_valid=1, out_ready=4'b0000.
  - Response: out_valid=4'b0100 next cycle and out_data2=0xDEADBEEF. A second word to lane 2 sees in_ready=0; a word to lane 1 sees in_ready=1.
- Streaming pass-through:
  - Stimulus: out_ready[0]=1, and words 1,2,3,4 sent to lane 0 on back-to-back cycles.
  - Response: in_ready stays 1, out_data0 shows 1,2,3,4 on consecutive cycles, and out_valid[0] stays high throughout.
- Stall stability:
  - Stimulus: lane 3 holds 0x55 with out_ready[3]=0 for 5 cycles while words go to lanes 0 and 1.
  - Response: out_data3 stays 0x55, out_valid[3] stays 1, and the other lanes receive their words.
- Flush:
  - Stimulus: all four lanes full, then flush=1 for one cycle with in_valid=1.
  - Response: in_ready=0, out_valid=4'b0000 after the edge, and the input word is not accepted.
- Async reset mid-operation:
  - Stimulus: rst asserted between clock edges while lanes 0 and 2 are full.
  - Response: out_valid=0 before the next edge. With ROUTER_STATS_EN, cnt0..3 read 0.
- Counter saturation (ROUTER_STATS_EN, CNT_W=4):
  - Stimulus: 20 handshakes on lane 1.
  - Response: cnt1=15 and stays at 15.
